// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle for uart_rx: serial line in, received byte and status out.
interface uart_rx_if;
    logic       RXD;
    logic [7:0] Data;
    logic       Data_valid;
    logic       Frame_err;
    logic       Busy;

    modport master (
        input  RXD,
        output Data,
        output Data_valid,
        output Frame_err,
        output Busy
    );

    modport slave (
        output RXD,
        input  Data,
        input  Data_valid,
        input  Frame_err,
        input  Busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a single-cycle Data_valid strobe.
// Define UART_RX_FRAME_ERR_EN to check the stop bit and drive Frame_err.
module uart_rx #(
    parameter logic [31:0] FREQ_CLK = 32'd100_000_000,
    parameter logic [31:0] RX_SPEED = 32'd115_200
) (
    input  logic     Clk,
    input  logic     Rst_n,
    uart_rx_if.master bus
);

    localparam logic [31:0] BIT_CYC  = FREQ_CLK / RX_SPEED + 32'd1;
    localparam logic [31:0] HALF_CYC = BIT_CYC / 32'd2;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        WAIT_IDLE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rxd_meta;
    logic        rxd_s;
    logic        rxd_prev;
    logic [1:0]  settle;
    logic        armed;
    logic [31:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  data_q;
    logic        vld_q;
    logic        cnt_clr;
    logic        sample_bit;
    logic        deliver;
`ifdef UART_RX_FRAME_ERR_EN
    logic        ferr;
    logic        ferr_q;
`endif

    // The synchronizer resets to 1, so a line held low through reset would look
    // like a falling edge; start detection is armed only once the real line is seen high.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
            settle   <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rxd_meta <= bus.RXD;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
            settle   <= {settle[0], 1'b1};
            if (settle[1] && rxd_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        sample_bit = 1'b0;
        deliver    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (armed && rxd_prev && !rxd_s) begin
                    state_nxt = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt == HALF_CYC) begin
                    state_nxt = rxd_s ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (cnt == BIT_CYC) begin
                    sample_bit = 1'b1;
                    cnt_clr    = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP_BIT;
                    end
                end
            end
            STOP_BIT: begin
                if (cnt == BIT_CYC) begin
`ifdef UART_RX_FRAME_ERR_EN
                    if (rxd_s) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
`else
                    deliver   = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating period counter: WAIT_IDLE can last arbitrarily long during a break.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= 32'd0;
        end else if ((state_nxt != state) || cnt_clr) begin
            cnt <= 32'd0;
        end else if (cnt != {32{1'b1}}) begin
            cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else if (state != DATA_BITS) begin
            bit_cnt <= 3'd0;
        end else if (sample_bit) begin
            shift[bit_cnt] <= rxd_s;
            bit_cnt        <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_q <= 8'h00;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= deliver;
            if (deliver) begin
                data_q <= shift;
            end
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr;
        end
    end

    assign bus.Frame_err = ferr_q;
`else
    assign bus.Frame_err = 1'b0;
`endif

    assign bus.Data       = data_q;
    assign bus.Data_valid = vld_q;
    assign bus.Busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: byte-level expectation queue versus observed Data_valid strobes.
module tb_uart_rx;

    localparam logic [31:0] FREQ_CLK = 32'd10_000_000;
    localparam logic [31:0] RX_SPEED = 32'd115_200;
    localparam int BIT_CYC  = int'(FREQ_CLK / RX_SPEED) + 1;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int FAST     = (BIT_CYC * 98 + 50) / 100;
    localparam int SLOW     = (BIT_CYC * 102 + 50) / 100;

    logic Clk = 1'b0;
    logic Rst_n;

    uart_rx_if bus ();

    uart_rx #(
        .FREQ_CLK(FREQ_CLK),
        .RX_SPEED(RX_SPEED)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int         checks = 0;
    int         fails = 0;
    int         vld_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       prev_pulse = 1'b0;

    // Continuous protocol observer: strobe exclusivity, strobe width, Data only moves with Data_valid.
    always @(negedge Clk) begin
        if (Rst_n !== 1'b1) begin
            prev_data  = bus.Data;
            prev_pulse = 1'b0;
        end else begin
            if (bus.Data_valid === 1'b1 || bus.Frame_err === 1'b1) begin
                checks++;
                if (bus.Data_valid === 1'b1 && bus.Frame_err === 1'b1) begin
                    fails++;
                    $display("FAIL pulse_exclusive: Data_valid=%b Frame_err=%b, required never both high", bus.Data_valid, bus.Frame_err);
                end
                if (prev_pulse) begin
                    fails++;
                    $display("FAIL pulse_width: strobe high on consecutive cycles at %0t, required one cycle", $time);
                end
            end
            if (bus.Data !== prev_data) begin
                checks++;
                if (bus.Data_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL data_hold: Data changed %h -> %h without Data_valid", prev_data, bus.Data);
                end
            end
            if (bus.Data_valid === 1'b1) begin
                vld_cnt++;
                got_q.push_back(bus.Data);
            end
            if (bus.Frame_err === 1'b1) ferr_cnt++;
            prev_pulse = (bus.Data_valid === 1'b1) || (bus.Frame_err === 1'b1);
            prev_data  = bus.Data;
        end
    end

    // Sender plus reference model: a well-formed frame yields its byte; a bad stop bit
    // yields the byte only when stop checking is compiled out.
    task automatic send_frame(input logic [7:0] b, input int period, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.RXD = f[i];
            repeat (period) @(posedge Clk);
        end
`ifdef UART_RX_FRAME_ERR_EN
        if (stop) begin
            exp_q.push_back(b);
            exp_data = b;
        end
`else
        exp_q.push_back(b);
        exp_data = b;
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.Busy !== 1'b0 && n < 4 * BIT_CYC) begin
            @(negedge Clk);
            n++;
        end
        repeat (4) @(negedge Clk);
    endtask

    task automatic clear_scoreboard();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.RXD = 1'b1;
        Rst_n   = 1'b0;
        repeat (5) @(negedge Clk);
        checks++;
        if (bus.Data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", bus.Data); end
        checks++;
        if (bus.Data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", bus.Data_valid); end
        checks++;
        if (bus.Frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b, required 0", bus.Frame_err); end
        checks++;
        if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", bus.Busy); end
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
    endtask

    task automatic test_basic();
        int f0;
        clear_scoreboard();
        f0 = ferr_cnt;
        send_frame(8'hA5, BIT_CYC, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() != 1) begin fails++; $display("FAIL basic_count: got %0d pulses, required 1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== 8'hA5) begin fails++; $display("FAIL basic_byte: got %h, required a5", got_q[0]); end
        end
        checks++;
        if (bus.Data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h, required a5", bus.Data); end
        checks++;
        if (ferr_cnt != f0) begin fails++; $display("FAIL basic_ferr: got %0d, required 0", ferr_cnt - f0); end
        checks++;
        if (bus.Busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b, required 0", bus.Busy); end
    endtask

    task automatic test_back_to_back();
        clear_scoreboard();
        send_frame(8'h00, BIT_CYC, 1'b1);
        send_frame(8'hFF, BIT_CYC, 1'b1);
        send_frame(8'h55, BIT_CYC, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count: got %0d pulses, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d0;
        int         f0;
        clear_scoreboard();
        d0 = bus.Data;
        f0 = ferr_cnt;
        bus.RXD = 1'b0;
        repeat (HALF_CYC / 2) @(negedge Clk);
        checks++;
        if (bus.Busy !== 1'b1) begin fails++; $display("FAIL glitch_start: Busy got %b, required 1", bus.Busy); end
        bus.RXD = 1'b1;
        repeat (BIT_CYC) @(negedge Clk);
        checks++;
        if (bus.Busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: Busy got %b, required 0", bus.Busy); end
        checks++;
        if (got_q.size() != 0 || ferr_cnt != f0) begin
            fails++;
            $display("FAIL glitch_pulse: got %0d valid %0d ferr, required none", got_q.size(), ferr_cnt - f0);
        end
        checks++;
        if (bus.Data !== d0) begin fails++; $display("FAIL glitch_data: got %h, required %h", bus.Data, d0); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d0;
        int         f0;
        clear_scoreboard();
        d0 = bus.Data;
        f0 = ferr_cnt;
        send_frame(8'h3C, BIT_CYC, 1'b0);
        repeat (5000) @(negedge Clk);
`ifdef UART_RX_FRAME_ERR_EN
        checks++;
        if (ferr_cnt - f0 != 1) begin fails++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - f0); end
        checks++;
        if (got_q.size() != 0) begin fails++; $display("FAIL ferr_valid: got %0d pulses, required 0", got_q.size()); end
        checks++;
        if (bus.Busy !== 1'b1) begin fails++; $display("FAIL ferr_wait: Busy got %b, required 1 during break", bus.Busy); end
        checks++;
        if (bus.Data !== d0) begin fails++; $display("FAIL ferr_data: got %h, required %h", bus.Data, d0); end
        bus.RXD = 1'b1;
        wait_idle();
        checks++;
        if (bus.Busy !== 1'b0) begin fails++; $display("FAIL ferr_release: Busy got %b, required 0", bus.Busy); end
        send_frame(8'h5A, BIT_CYC, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            fails++;
            $display("FAIL ferr_recover: got %0d pulses first %h, required 1 pulse 5a", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
`else
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
            fails++;
            $display("FAIL nochk_byte: got %0d pulses first %h, required 1 pulse 3c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        checks++;
        if (ferr_cnt != f0) begin fails++; $display("FAIL nochk_ferr: got %0d, required 0", ferr_cnt - f0); end
        checks++;
        if (bus.Busy !== 1'b0) begin fails++; $display("FAIL nochk_busy: got %b, required 0 during break", bus.Busy); end
        checks++;
        if (bus.Data !== 8'h3C) begin fails++; $display("FAIL nochk_data: got %h, required 3c (prev %h)", bus.Data, d0); end
        bus.RXD = 1'b1;
        wait_idle();
`endif
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] f;
        int         f0;
        clear_scoreboard();
        f0 = ferr_cnt;
        f  = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.RXD = f[i];
            if (i == 5) begin
                repeat (BIT_CYC / 2) @(posedge Clk);
                #1;
                checks++;
                if (bus.Busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before: got %b, required 1", bus.Busy); end
                Rst_n = 1'b0;
                #1;
                checks++;
                if (bus.Busy !== 1'b0 || bus.Data !== 8'h00 || bus.Data_valid !== 1'b0 || bus.Frame_err !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_mid_async: Busy=%b Data=%h vld=%b ferr=%b, required 0/00/0/0", bus.Busy, bus.Data, bus.Data_valid, bus.Frame_err);
                end
                repeat (3) @(negedge Clk);
                Rst_n = 1'b1;
                repeat (BIT_CYC / 2) @(posedge Clk);
            end else begin
                repeat (BIT_CYC) @(posedge Clk);
            end
        end
        exp_data = 8'h00;
        repeat (2 * BIT_CYC) @(negedge Clk);
        checks++;
        if (got_q.size() != 0 || ferr_cnt != f0) begin
            fails++;
            $display("FAIL rst_mid_pulse: got %0d valid %0d ferr, required none", got_q.size(), ferr_cnt - f0);
        end
        checks++;
        if (bus.Data !== exp_data) begin fails++; $display("FAIL rst_mid_data: got %h, required %h", bus.Data, exp_data); end
        send_frame(8'h7E, BIT_CYC, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() != 1 || bus.Data !== 8'h7E) begin
            fails++;
            $display("FAIL rst_mid_next: got %0d pulses Data %h, required 1 pulse 7e", got_q.size(), bus.Data);
        end
    endtask

    task automatic test_baud_tolerance();
        int f0;
        clear_scoreboard();
        f0 = ferr_cnt;
        send_frame(8'hC3, FAST, 1'b1);
        send_frame(8'hC3, SLOW, 1'b1);
        wait_idle();
        checks++;
        if (got_q.size() != 2) begin
            fails++;
            $display("FAIL baud_count: got %0d pulses, required 2", got_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_q[i] !== 8'hC3) begin fails++; $display("FAIL baud_byte%0d: got %h, required c3", i, got_q[i]); end
            end
        end
        checks++;
        if (ferr_cnt != f0) begin fails++; $display("FAIL baud_ferr: got %0d, required 0", ferr_cnt - f0); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         per;
        clear_scoreboard();
        for (int k = 0; k < 5; k++) begin
            b   = 8'($urandom_range(0, 255));
            per = int'($urandom_range(FAST, SLOW));
            bus.RXD = 1'b1;
            repeat ($urandom_range(0, 20)) @(posedge Clk);
            send_frame(b, per, 1'b1);
        end
        wait_idle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d pulses, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (bus.Data !== exp_data) begin fails++; $display("FAIL rand_data: got %h, required %h", bus.Data, exp_data); end
    endtask

    initial begin
        #(80_000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud_tolerance();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
